seg_disp_arbiter: RTL and testbench
===================================

// Module: seg_disp_arbiter
// PURPOSE
//  Owns the 6-digit seg_dynamic driver and shares it between two requesters: IR receiver (decoded
//  command byte, high priority, shown for a fixed hold time) and a background value source (shown
//  otherwise). Drives data/point/sign/seg_en of seg_dynamic from registers; sits between IR decoder
//  and seg_dynamic in the top level.
// PARAMETERS
//  CNT_MS_MAX  16'd49_999  prescaler terminal count; one ms_tick per CNT_MS_MAX+1 clocks (50 MHz -> 1 ms)
//  HOLD_MS     16'd3000    ms an IR command stays on display after last ir_valid/ir_repeat (>=1)
// PORTS
//  sys_clk     in   1   system clock
//  sys_rst     in   1   reset, synchronous, active-high
//  ir_valid    in   1   1-cycle pulse: new IR command on ir_data
//  ir_repeat   in   1   1-cycle pulse: IR repeat frame (key held)
//  ir_data     in   8   IR command byte, sampled when ir_valid=1
//  bg_en       in   1   background source has a value to show (level)
//  bg_data     in   20  background value, binary, 0..999_999 meaningful
//  bg_point    in   6   background decimal-point mask, bit0 = rightmost digit
//  bg_sign     in   1   background value negative
//  data        out  20  to seg_dynamic.data
//  point       out  6   to seg_dynamic.point
//  sign        out  1   to seg_dynamic.sign
//  seg_en      out  1   to seg_dynamic.seg_en
//  ir_active   out  1   1 while state = S_IR
// BEHAVIOUR
//  Reset (sys_rst=1 at posedge): state=S_OFF; data=0, point=0, sign=0, seg_en=0, ir_active=0;
//   prescaler and hold_cnt = 0; latched IR byte = 0. Reset mid-hold discards the IR command.
//  ms_tick: prescaler counts 0..CNT_MS_MAX, wraps to 0; ms_tick=1 in the cycle count==CNT_MS_MAX.
//   Prescaler cleared in the same cycle any ir_valid or accepted ir_repeat is seen (hold restarts
//   on a full-ms boundary).
//  States S_OFF, S_BG, S_IR. Priority per cycle, highest first:
//   1 ir_valid (any state) -> S_IR, latch ir_data, hold_cnt=0.
//   2 S_IR, ir_repeat -> stay, hold_cnt=0, latched byte unchanged. ir_repeat outside S_IR ignored.
//   3 S_IR, ms_tick & hold_cnt==HOLD_MS-1 -> S_BG if bg_en else S_OFF; else ms_tick: hold_cnt+1.
//   4 S_BG & !bg_en -> S_OFF;  S_OFF & bg_en -> S_BG.
//  Simultaneous ir_valid+ir_repeat: treated as ir_valid. ir_valid in the timeout cycle: stays S_IR.
//  Outputs registered, driven from next state (1-cycle latency input -> output):
//   S_OFF: data=0, point=0, sign=0, seg_en=0.
//   S_IR : data={12'd0, latched byte} (decimal 0..255), point=0, sign=0, seg_en=1.
//   S_BG : data=min(bg_data, 999_999), point=bg_point, sign=bg_sign, seg_en=1; re-sampled every
//          cycle (tracks live). Clamp compare is unsigned 20-bit.
//  ir_active = (next state == S_IR), registered with the other outputs.
//  hold_cnt 16-bit, never exceeds HOLD_MS-1; no wrap possible.
// STRUCTURE
//  seg_disp_pkg: state enum encoding (S_OFF=2'd0, S_BG=2'd1, S_IR=2'd2), DISP_MAX=20'd999_999,
//   IR_PAD_W=12.
//  Sub-module ms_tick_gen (param CNT_MS_MAX; in sys_clk, sys_rst, clr; out ms_tick).
//  Top: FSM + hold counter + registered output mux.
// TESTING (CNT_MS_MAX=9, HOLD_MS=3 for sim speed)
//  1 Reset, bg_en=0 -> seg_en=0, data=0 held; set bg_en=1,bg_data=1234,bg_point=6'b000100 -> next
//    cycle data=1234, point=000100, seg_en=1.
//  2 In S_BG pulse ir_valid,ir_data=8'hA5 -> next cycle data=165, point=0, ir_active=1; after exactly
//    30 clocks from pulse returns to data=1234, ir_active=0.
//  3 Same as 2 with ir_repeat at clock 25 -> display 165 held until clock 55; ir_repeat in S_BG
//    -> no change.
//  4 ir_valid=8'h10 then ir_valid=8'h20 at clock 15 -> data=32, hold timer restarts from clock 15.
//  5 bg_data=20'd1_048_575, bg_sign=1 -> data=999_999, sign=1; bg_en drops during S_IR -> timeout
//    goes to S_OFF, seg_en=0.
//  6 sys_rst asserted mid S_IR -> next cycle all outputs 0, state S_OFF; ir_valid+ir_repeat same
//    cycle -> new byte latched.

Source files
------------

// File: rtl/seg_disp_arbiter_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// The arbiter shares one seg_dynamic driver between an IR command display and a background value.
package seg_disp_pkg;

    typedef enum logic [1:0] {
        S_OFF = 2'd0,
        S_BG  = 2'd1,
        S_IR  = 2'd2
    } disp_state_t;

    localparam logic [19:0] DISP_MAX = 20'd999_999;
    localparam int          IR_PAD_W = 12;

    // The driver only has six digits, so any larger background value saturates.
    function automatic logic [19:0] clamp_disp(input logic [19:0] value);
        return (value > DISP_MAX) ? DISP_MAX : value;
    endfunction

endpackage

// File: rtl/seg_disp_arbiter_if.sv
// Requester inputs and seg_dynamic-facing outputs of the display arbiter.
// The master side drives the IR and background requests; the arbiter is the slave.
interface seg_disp_arbiter_if;

    logic        ir_valid;
    logic        ir_repeat;
    logic [7:0]  ir_data;
    logic        bg_en;
    logic [19:0] bg_data;
    logic [5:0]  bg_point;
    logic        bg_sign;

    logic [19:0] data;
    logic [5:0]  point;
    logic        sign;
    logic        seg_en;
    logic        ir_active;

    modport master (
        output ir_valid, ir_repeat, ir_data, bg_en, bg_data, bg_point, bg_sign,
        input  data, point, sign, seg_en, ir_active
    );

    modport slave (
        input  ir_valid, ir_repeat, ir_data, bg_en, bg_data, bg_point, bg_sign,
        output data, point, sign, seg_en, ir_active
    );

endinterface

// File: rtl/seg_disp_arbiter_ms_tick_gen.sv
// Millisecond prescaler: emits one ms_tick per CNT_MS_MAX+1 clocks.
// Clearing restarts the count so an IR hold always begins on a full-millisecond boundary.
module ms_tick_gen #(
    parameter logic [15:0] CNT_MS_MAX = 16'd49_999
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clr,
    output logic ms_tick
);

    logic [15:0] cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt <= '0;
        end else if (clr || (cnt == CNT_MS_MAX)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    assign ms_tick = (cnt == CNT_MS_MAX);

endmodule

// File: rtl/seg_disp_arbiter.sv
// Arbitrates the six-digit display between IR commands (held for HOLD_MS ms) and a background value.
// All display outputs are registered from the next state, giving one cycle of input-to-output latency.
module seg_disp_arbiter
    import seg_disp_pkg::*;
#(
    parameter logic [15:0] CNT_MS_MAX = 16'd49_999,
    parameter logic [15:0] HOLD_MS    = 16'd3000
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    seg_disp_arbiter_if.slave    bus
);

    localparam logic [15:0] HOLD_LAST = HOLD_MS - 16'd1;

    disp_state_t state, state_nxt;
    logic [15:0] hold_cnt, hold_cnt_nxt;
    logic [7:0]  ir_byte, ir_byte_nxt;
    logic        ms_tick;
    logic        presc_clr;

    logic [19:0] data_nxt;
    logic [5:0]  point_nxt;
    logic        sign_nxt;
    logic        seg_en_nxt;

    // A repeat frame only refreshes the hold when an IR command is actually on display.
    assign presc_clr = bus.ir_valid || (bus.ir_repeat && (state == S_IR));

    ms_tick_gen #(
        .CNT_MS_MAX (CNT_MS_MAX)
    ) u_ms_tick_gen (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clr     (presc_clr),
        .ms_tick (ms_tick)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= S_OFF;
            hold_cnt <= '0;
            ir_byte  <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            ir_byte  <= ir_byte_nxt;
        end
    end

    // A fresh command beats everything, including a timeout landing in the same cycle.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        ir_byte_nxt  = ir_byte;
        if (bus.ir_valid) begin
            state_nxt    = S_IR;
            hold_cnt_nxt = '0;
            ir_byte_nxt  = bus.ir_data;
        end else begin
            case (state)
                S_IR: begin
                    if (bus.ir_repeat) begin
                        hold_cnt_nxt = '0;
                    end else if (ms_tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            state_nxt    = bus.bg_en ? S_BG : S_OFF;
                            hold_cnt_nxt = '0;
                        end else begin
                            hold_cnt_nxt = hold_cnt + 16'd1;
                        end
                    end
                end
                S_BG: begin
                    if (!bus.bg_en) begin
                        state_nxt = S_OFF;
                    end
                end
                default: begin
                    if (bus.bg_en) begin
                        state_nxt = S_BG;
                    end
                end
            endcase
        end
    end

    always_comb begin
        data_nxt   = '0;
        point_nxt  = '0;
        sign_nxt   = 1'b0;
        seg_en_nxt = 1'b0;
        case (state_nxt)
            S_IR: begin
                data_nxt   = {{IR_PAD_W{1'b0}}, ir_byte_nxt};
                seg_en_nxt = 1'b1;
            end
            S_BG: begin
                data_nxt   = clamp_disp(bus.bg_data);
                point_nxt  = bus.bg_point;
                sign_nxt   = bus.bg_sign;
                seg_en_nxt = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            bus.data      <= '0;
            bus.point     <= '0;
            bus.sign      <= 1'b0;
            bus.seg_en    <= 1'b0;
            bus.ir_active <= 1'b0;
        end else begin
            bus.data      <= data_nxt;
            bus.point     <= point_nxt;
            bus.sign      <= sign_nxt;
            bus.seg_en    <= seg_en_nxt;
            bus.ir_active <= (state_nxt == S_IR);
        end
    end

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Bench for seg_disp_arbiter: background vector table, hand-written IR hold sequences and random traffic.
// The reference model tracks the IR hold as an absolute expiry cycle rather than a tick counter.
module tb_seg_disp_arbiter;

    localparam logic [15:0] CNT_MS_MAX = 16'd9;
    localparam logic [15:0] HOLD_MS    = 16'd3;
    localparam int          HOLD_CLKS  = int'(HOLD_MS) * (int'(CNT_MS_MAX) + 1);

    logic sys_clk = 1'b0;
    logic sys_rst;

    seg_disp_arbiter_if bus ();

    seg_disp_arbiter #(
        .CNT_MS_MAX (CNT_MS_MAX),
        .HOLD_MS    (HOLD_MS)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    typedef enum {M_OFF, M_BG, M_IR} mode_t;

    typedef struct {
        logic        bg_en;
        logic [19:0] bg_data;
        logic [5:0]  bg_point;
        logic        bg_sign;
        logic [19:0] exp_data;
        logic [5:0]  exp_point;
        logic        exp_sign;
        logic        exp_seg_en;
    } bg_vec_t;

    bg_vec_t     vecs [8];
    mode_t       m_mode;
    logic [7:0]  m_byte;
    int          m_expire;
    int          cyc;
    int          vectors;
    int          miscompares;
    logic [19:0] e_data;
    logic [5:0]  e_point;
    logic        e_sign;
    logic        e_seg_en;
    logic        e_active;

    // Reference model: on display until HOLD_CLKS clocks after the last command or repeat.
    task automatic modelEdge();
        if (sys_rst) begin
            m_mode = M_OFF;
            m_byte = 8'd0;
        end else if (bus.ir_valid) begin
            m_mode   = M_IR;
            m_byte   = bus.ir_data;
            m_expire = cyc + HOLD_CLKS;
        end else if (m_mode == M_IR) begin
            if (bus.ir_repeat) m_expire = cyc + HOLD_CLKS;
            else if (cyc >= m_expire) m_mode = bus.bg_en ? M_BG : M_OFF;
        end else if (m_mode == M_BG && !bus.bg_en) begin
            m_mode = M_OFF;
        end else if (m_mode == M_OFF && bus.bg_en) begin
            m_mode = M_BG;
        end
        e_data = 20'd0; e_point = 6'd0; e_sign = 1'b0; e_seg_en = 1'b0; e_active = 1'b0;
        if (m_mode == M_IR) begin
            e_data = 20'(m_byte); e_seg_en = 1'b1; e_active = 1'b1;
        end else if (m_mode == M_BG) begin
            e_data   = (int'(bus.bg_data) > 999_999) ? 20'd999_999 : bus.bg_data;
            e_point  = bus.bg_point;
            e_sign   = bus.bg_sign;
            e_seg_en = 1'b1;
        end
    endtask

    task automatic checkOutput(input string name);
        vectors++;
        if ({bus.data, bus.point, bus.sign, bus.seg_en, bus.ir_active} !==
            {e_data, e_point, e_sign, e_seg_en, e_active}) begin
            miscompares++;
            $display("[TB] FAIL %s cyc=%0d got data=%0d point=%b sign=%b seg_en=%b ir_active=%b, want data=%0d point=%b sign=%b seg_en=%b ir_active=%b",
                     name, cyc, bus.data, bus.point, bus.sign, bus.seg_en, bus.ir_active,
                     e_data, e_point, e_sign, e_seg_en, e_active);
        end
    endtask

    task automatic checkConst(input string name, input logic [19:0] d, input logic [5:0] p,
                              input logic s, input logic en, input logic act);
        vectors++;
        if ({bus.data, bus.point, bus.sign, bus.seg_en, bus.ir_active} !== {d, p, s, en, act}) begin
            miscompares++;
            $display("[TB] FAIL %s cyc=%0d got data=%0d point=%b sign=%b seg_en=%b ir_active=%b, want data=%0d point=%b sign=%b seg_en=%b ir_active=%b",
                     name, cyc, bus.data, bus.point, bus.sign, bus.seg_en, bus.ir_active,
                     d, p, s, en, act);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic iv, input logic irp, input logic [7:0] id);
        sys_rst       = rst;
        bus.ir_valid  = iv;
        bus.ir_repeat = irp;
        bus.ir_data   = id;
        @(posedge sys_clk);
        cyc++;
        modelEdge();
        #1;
        checkOutput("model");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 20'd1234,      6'b000100, 1'b0, 20'd1234,    6'b000100, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 20'd999_999,   6'b111111, 1'b1, 20'd999_999, 6'b111111, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 20'd1_000_000, 6'b000000, 1'b0, 20'd999_999, 6'b000000, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 20'hFFFFF,     6'b100001, 1'b1, 20'd999_999, 6'b100001, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 20'd0,         6'b000000, 1'b1, 20'd0,       6'b000000, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 20'd5555,      6'b010101, 1'b1, 20'd0,       6'b000000, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 20'd999_998,   6'b001000, 1'b0, 20'd999_998, 6'b001000, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 20'd54321,     6'b000100, 1'b0, 20'd54321,   6'b000100, 1'b0, 1'b1};

        vectors = 0; miscompares = 0; cyc = 0;
        m_mode = M_OFF; m_byte = 8'd0; m_expire = 0;
        sys_rst = 1'b1;
        bus.ir_valid = 1'b0; bus.ir_repeat = 1'b0; bus.ir_data = 8'd0;
        bus.bg_en = 1'b0; bus.bg_data = 20'd0; bus.bg_point = 6'd0; bus.bg_sign = 1'b0;
        $display("[TB] seg_disp_arbiter bench starting");

        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
        checkConst("reset_state", 20'd0, 6'd0, 1'b0, 1'b0, 1'b0);
        idle(3);
        checkConst("reset_hold_off", 20'd0, 6'd0, 1'b0, 1'b0, 1'b0);

        bus.bg_en = 1'b1; bus.bg_data = 20'd1234; bus.bg_point = 6'b000100;
        idle(1);
        checkConst("bg_show", 20'd1234, 6'b000100, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            bus.bg_en = vecs[i].bg_en; bus.bg_data = vecs[i].bg_data;
            bus.bg_point = vecs[i].bg_point; bus.bg_sign = vecs[i].bg_sign;
            idle(1);
            checkConst($sformatf("bg_vec%0d", i), vecs[i].exp_data, vecs[i].exp_point,
                       vecs[i].exp_sign, vecs[i].exp_seg_en, 1'b0);
        end

        bus.bg_en = 1'b1; bus.bg_data = 20'd1234; bus.bg_point = 6'b000100; bus.bg_sign = 1'b0;
        idle(1);

        // IR command holds for exactly HOLD_CLKS clocks after the pulse.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hA5);
        checkConst("ir_show", 20'd165, 6'd0, 1'b0, 1'b1, 1'b1);
        idle(HOLD_CLKS - 1);
        checkConst("ir_last_hold", 20'd165, 6'd0, 1'b0, 1'b1, 1'b1);
        idle(1);
        checkConst("ir_timeout", 20'd1234, 6'b000100, 1'b0, 1'b1, 1'b0);

        // Repeat at clock 25 stretches the hold to clock 55.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hA5);
        idle(24);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        idle(29);
        checkConst("repeat_hold", 20'd165, 6'd0, 1'b0, 1'b1, 1'b1);
        idle(1);
        checkConst("repeat_timeout", 20'd1234, 6'b000100, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkConst("repeat_in_bg", 20'd1234, 6'b000100, 1'b0, 1'b1, 1'b0);

        // Second command at clock 15 replaces the byte and restarts the hold.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h10);
        checkConst("cmd_first", 20'd16, 6'd0, 1'b0, 1'b1, 1'b1);
        idle(14);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h20);
        checkConst("cmd_second", 20'd32, 6'd0, 1'b0, 1'b1, 1'b1);
        idle(29);
        checkConst("cmd_second_hold", 20'd32, 6'd0, 1'b0, 1'b1, 1'b1);
        idle(1);
        checkConst("cmd_second_timeout", 20'd1234, 6'b000100, 1'b0, 1'b1, 1'b0);

        // Saturated background, then bg_en drops during the hold so the timeout blanks the display.
        bus.bg_data = 20'd1_048_575; bus.bg_sign = 1'b1;
        idle(1);
        checkConst("clamp_sign", 20'd999_999, 6'b000100, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h07);
        bus.bg_en = 1'b0;
        idle(HOLD_CLKS - 1);
        checkConst("bg_drop_hold", 20'd7, 6'd0, 1'b0, 1'b1, 1'b1);
        idle(1);
        checkConst("bg_drop_off", 20'd0, 6'd0, 1'b0, 1'b0, 1'b0);

        // Reset mid-hold, then simultaneous valid+repeat latches the new byte.
        bus.bg_en = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h33);
        idle(5);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkConst("reset_mid_ir", 20'd0, 6'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h5A);
        checkConst("valid_and_repeat", 20'd90, 6'd0, 1'b0, 1'b1, 1'b1);
        idle(HOLD_CLKS);
        checkConst("after_reset_timeout", 20'd999_999, 6'b000100, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 24) == 0) bus.bg_en = ~bus.bg_en;
            bus.bg_data  = 20'($urandom_range(0, 1_048_575));
            bus.bg_point = 6'($urandom);
            bus.bg_sign  = 1'($urandom);
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 14) == 0), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
